// File: rtl/hdng_err_gen.sv
// hdng_err_gen: calibrates a yaw-rate offset, integrates compensated yaw into a heading
// and produces a registered, saturated heading error against the desired heading.
module hdng_err_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cal,
  input  logic        vld,
  input  logic [15:0] yaw_rt,
  input  logic [11:0] dsrd_hdng,
  output logic        cal_done,
  output logic [11:0] heading,
  output logic [9:0]  err_sat,
  output logic        hdng_vld
);
  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
  state_t      state_q, state_d;
  logic [19:0] acc_q, acc_d, acc_sum;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] yaw_off_q, yaw_off_d, yaw_comp;
  logic [16:0] comp_wide;
  logic [23:0] hdng_q, hdng_d;
  logic [11:0] err;
  logic [9:0]  err_sat_q, err_sat_d;
  logic        pend_q, pend_d, cal_done_q, cal_done_d, hdng_vld_q, hdng_vld_d;
  logic        cal_smp, run_smp, cal_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = strt_cal ? CAL : cal_last ? RUN : state_q;
  always_comb begin
    cal_smp  = (state_q == CAL) && vld && !strt_cal;
    run_smp  = (state_q == RUN) && vld && !strt_cal;
    cal_last = cal_smp && (cnt_q == 4'd15);
  end
  // 17-bit difference; a sign/carry disagreement means the 16-bit result overflowed
  always_comb begin
    acc_sum    = acc_q + {{4{yaw_rt[15]}}, yaw_rt};
    comp_wide  = {yaw_rt[15], yaw_rt} - {yaw_off_q[15], yaw_off_q};
    yaw_comp   = (comp_wide[16] ^ comp_wide[15]) ? {comp_wide[16], {15{~comp_wide[16]}}} : comp_wide[15:0];
    err        = heading - dsrd_hdng;
    acc_d      = strt_cal ? 20'd0 : cal_smp ? acc_sum : acc_q;
    cnt_d      = strt_cal ? 4'd0 : cal_smp ? cnt_q + 4'd1 : cnt_q;
    yaw_off_d  = cal_last ? acc_sum[19:4] : yaw_off_q;
    hdng_d     = strt_cal ? 24'd0 : run_smp ? hdng_q + {{8{yaw_comp[15]}}, yaw_comp} : hdng_q;
    pend_d     = run_smp;
    hdng_vld_d = pend_q && !strt_cal;
    err_sat_d  = !hdng_vld_d ? err_sat_q :
                 (err[11:9] == 3'b000 || err[11:9] == 3'b111) ? err[9:0] :
                 err[11] ? 10'h200 : 10'h1FF;
    cal_done_d = cal_last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      yaw_off_q  <= '0;
      hdng_q     <= '0;
      err_sat_q  <= '0;
      pend_q     <= 1'b0;
      hdng_vld_q <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      yaw_off_q  <= yaw_off_d;
      hdng_q     <= hdng_d;
      err_sat_q  <= err_sat_d;
      pend_q     <= pend_d;
      hdng_vld_q <= hdng_vld_d;
      cal_done_q <= cal_done_d;
    end
  assign heading  = hdng_q[23:12];
  assign err_sat  = err_sat_q;
  assign hdng_vld = hdng_vld_q;
  assign cal_done = cal_done_q;
endmodule

// File: tb/tb_hdng_err_gen.sv
// tb_hdng_err_gen: randomized + directed scoreboard bench for hdng_err_gen.
module tb_hdng_err_gen;
  logic        clk = 1'b0, rst_n = 1'b0, strt_cal = 1'b0, vld = 1'b0;
  logic [15:0] yaw_rt = '0;
  logic [11:0] dsrd_hdng = '0;
  logic        cal_done, hdng_vld;
  logic [11:0] heading;
  logic [9:0]  err_sat;
  hdng_err_gen dut (.clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld), .yaw_rt(yaw_rt),
                    .dsrd_hdng(dsrd_hdng), .cal_done(cal_done), .heading(heading),
                    .err_sat(err_sat), .hdng_vld(hdng_vld));
  always #5 clk = ~clk;
  typedef struct {int e; int hd;} ent_t;
  ent_t hq[$];
  int   cq[$];
  int   hist[65536];
  int   cyc = 0, checks = 0, errors = 0;
  int   m_mode = 0, m_sum = 0, m_n = 0, m_off = 0, m_hd = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int hsx(int hd);
    logic signed [11:0] h;
    h = hd[23:12];
    return int'(h);
  endfunction
  function automatic int exp_err(int hd, int d);
    logic signed [11:0] h, dd, e;
    h = hd[23:12];
    dd = 12'(d);
    e = h - dd;
    return (e > 511) ? 511 : (e < -512) ? -512 : int'(e);
  endfunction
  // reference model: advances at each driven sample using the spec's arithmetic
  task automatic step(bit s, bit v, int yaw, int d);
    int ed, comp;
    @(negedge clk);
    #1;
    ed = cyc + 1;
    strt_cal = s;
    vld = v;
    yaw_rt = 16'(yaw);
    dsrd_hdng = 12'(d);
    hist[ed] = d;
    if (s) begin
      m_mode = 1; m_sum = 0; m_n = 0; m_hd = 0;
      while (hq.size() > 0 && hq[$].e == ed - 1) void'(hq.pop_back());
    end else if (v && m_mode == 1) begin
      m_sum += yaw;
      m_n++;
      if (m_n == 16) begin
        m_off = m_sum / 16;
        if (m_sum < 0 && m_sum % 16 != 0) m_off--;
        m_mode = 2;
        cq.push_back(ed);
      end
    end else if (v && m_mode == 2) begin
      comp = yaw - m_off;
      comp = (comp > 32767) ? 32767 : (comp < -32768) ? -32768 : comp;
      m_hd = (m_hd + comp) & 32'h00FF_FFFF;
      hq.push_back('{ed, m_hd});
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    strt_cal = 1'b0;
    vld = 1'b0;
    m_mode = 0; m_sum = 0; m_n = 0; m_off = 0; m_hd = 0;
    hq.delete();
    cq.delete();
    #1;
    chk("rst_cal_done", int'(cal_done), 0);
    chk("rst_hdng_vld", int'(hdng_vld), 0);
    chk("rst_heading", int'(heading), 0);
    chk("rst_err_sat", int'(err_sat), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask
  task automatic cal(int yaw);
    step(1, 0, 0, 0);
    repeat (16) step(0, 1, yaw, 0);
    step(0, 0, 0, 0);
  endtask
  // monitor: pops the scoreboard on every output strobe and flags missing strobes
  ent_t me;
  int   eh;
  always @(negedge clk) if (rst_n) begin
    if (hdng_vld) begin
      if (hq.size() == 0) chk("unexpected_hdng_vld", 1, 0);
      else begin
        me = hq.pop_front();
        eh = (hq.size() > 0 && hq[0].e == me.e + 1) ? hq[0].hd : me.hd;
        chk("hdng_vld_cycle", cyc, me.e + 1);
        chk("err_sat", int'($signed(err_sat)), exp_err(me.hd, hist[me.e + 1]));
        chk("heading", int'($signed(heading)), hsx(eh));
      end
    end
    while (hq.size() > 0 && hq[0].e + 1 < cyc) begin
      chk("missed_hdng_vld", 0, 1);
      void'(hq.pop_front());
    end
    if (cal_done) begin
      if (cq.size() == 0) chk("unexpected_cal_done", 1, 0);
      else chk("cal_done_cycle", cyc, cq.pop_front());
    end
    while (cq.size() > 0 && cq[0] < cyc) begin
      chk("missed_cal_done", 0, 1);
      void'(cq.pop_front());
    end
  end
  task automatic check_now(string nm, int act_sel, int exp);
    @(negedge clk);
    chk(nm, act_sel == 0 ? int'($signed(heading)) : int'($signed(err_sat)), exp);
  endtask
  initial begin
    int r, yaw;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("init_heading", int'(heading), 0);
    chk("init_err_sat", int'(err_sat), 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1000 * (i + 1), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("idle_hdng_vld", int'(hdng_vld), 0);
    chk("idle_cal_done", int'(cal_done), 0);
    chk("idle_heading", int'(heading), 0);
    chk("idle_err_sat", int'(err_sat), 0);
    cal(100);
    step(0, 1, 100, 0);
    step(0, 0, 0, 0);
    check_now("cal100_heading", 0, 0);
    cal(0);
    repeat (3) step(0, 1, 4096, 0);
    step(0, 0, 0, 0);
    check_now("int_heading", 0, 3);
    cal(0);
    step(0, 1, 0, 1024);
    step(0, 0, 0, 1024);
    check_now("err_neg_clamp", 1, -512);
    step(0, 1, 0, -100);
    step(0, 0, 0, -100);
    check_now("err_pos", 1, 100);
    cal(0);
    repeat (255) step(0, 1, 32767, -2048);
    step(0, 1, 28927, -2048);
    step(0, 0, 0, -2048);
    check_now("wrap_heading", 0, 2047);
    check_now("wrap_err", 1, -1);
    cal(-100);
    step(0, 1, 32767, 0);
    step(0, 0, 0, 0);
    check_now("sat_heading", 0, 7);
    step(0, 1, 500, 0);
    step(1, 1, 500, 0);
    repeat (3) step(0, 0, 0, 0);
    check_now("recal_heading", 0, 0);
    repeat (15) step(0, 1, 300, 0);
    step(0, 0, 0, 0);
    step(0, 1, 300, 0);
    step(0, 1, 300, 0);
    step(0, 0, 0, 0);
    check_now("recal_done_heading", 0, 0);
    step(0, 1, 5000, 0);
    do_reset();
    step(0, 1, 5000, 0);
    repeat (3) step(0, 0, 0, 0);
    check_now("post_rst_heading", 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      yaw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                         : int'($urandom_range(0, 4000)) - 2000;
      if (r < 3) do_reset();
      else step(r < 18, $urandom_range(0, 1) == 1, yaw, int'($urandom_range(0, 4095)) - 2048);
    end
    repeat (4) step(0, 0, 0, 0);
    @(negedge clk);
    chk("drain_hq", hq.size(), 0);
    chk("drain_cq", cq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
